// File: rtl/minilab_pkg.sv
// ----------------------------------------------------------------------------
// minilab_pkg
//   Shared constants and types for the matrix-load / MAC compute path.
//   The loader FSM state type lives here so the compute FSM can decode it.
//
//   Contents:
//     DATA_WIDTH      byte width pushed into each matrix FIFO
//     WORD_WIDTH      memory word width (one full row of bytes)
//     NUM_ROWS        words fetched per load = FIFOs fed (B vector + 8 A rows)
//     BYTES_PER_WORD  bytes unpacked from each memory word
//     loader_state_t  IDLE / REQ / WAIT / UNPACK / DONE
//     loader_busy()   true for the states in which a load is in flight
// ----------------------------------------------------------------------------
package minilab_pkg;

  localparam int DATA_WIDTH     = 8;
  localparam int WORD_WIDTH     = 64;
  localparam int NUM_ROWS       = 9;
  localparam int BYTES_PER_WORD = WORD_WIDTH / DATA_WIDTH;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    UNPACK = 3'd3,
    DONE   = 3'd4
  } loader_state_t;

  // A load is in flight from the first read request until the last byte push.
  function automatic logic loader_busy(input loader_state_t s);
    return (s == REQ) || (s == WAIT) || (s == UNPACK);
  endfunction

endpackage

// File: rtl/mem_fifo_loader_word_unpacker.sv
// ----------------------------------------------------------------------------
// word_unpacker
//   Holds one memory word and presents it one byte at a time, least
//   significant byte first. Each shift drops the byte just consumed and
//   advances the byte index; last_byte_o marks the final byte of the word.
//
//   Ports:
//     clk          in   clock, rising edge
//     rst_n        in   asynchronous active-low reset
//     load_i       in   capture word_i and restart at byte 0
//     word_i       in   WORD_WIDTH word to unpack
//     shift_i      in   current byte consumed, advance to the next one
//     byte_o       out  current byte (low DATA_WIDTH bits of the word)
//     last_byte_o  out  current byte is the last one of the word
// ----------------------------------------------------------------------------
module word_unpacker #(
  parameter int DATA_WIDTH = 8,
  parameter int WORD_WIDTH = 64,
  parameter int IDX_W      = $clog2(WORD_WIDTH / DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [WORD_WIDTH-1:0] word_i,
  input  logic                  shift_i,
  output logic [DATA_WIDTH-1:0] byte_o,
  output logic                  last_byte_o
);

  localparam int BYTES = WORD_WIDTH / DATA_WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  logic [WORD_WIDTH-1:0] shift_q;
  logic [IDX_W-1:0]      byte_idx_q;

  // Load wins over shift; the loader never asks for both in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      byte_idx_q <= '0;
    end else if (load_i) begin
      shift_q    <= word_i;
      byte_idx_q <= '0;
    end else if (shift_i) begin
      shift_q    <= shift_q >> DATA_WIDTH;
      byte_idx_q <= byte_idx_q + 1'b1;
    end
  end

  assign byte_o      = shift_q[DATA_WIDTH-1:0];
  assign last_byte_o = (byte_idx_q == LAST_IDX);

endmodule

// File: rtl/mem_fifo_loader.sv
// ----------------------------------------------------------------------------
// mem_fifo_loader
//   Avalon-MM read master that fills the matrix input FIFOs before compute.
//   Reads NUM_ROWS words from BASE_ADDR upward (one outstanding read at a
//   time), splits each word into bytes LSB first and pushes them into FIFO r
//   for row r. Raises done once every row is loaded; start reloads.
//
//   Ports:
//     clk            in   clock, rising edge
//     rst_n          in   asynchronous active-low reset
//     start          in   begin a load when idle or done (ignored while busy)
//     address        out  Avalon word address, registered
//     read           out  Avalon read request, registered, held until accepted
//     readdata       in   Avalon read data
//     readdatavalid  in   readdata valid (only honoured while waiting for it)
//     waitrequest    in   slave stall
//     fifo_data      out  byte shared by all FIFO write ports
//     fifo_wrreq     out  one-hot FIFO write strobe, bit r -> FIFO r
//     fifo_wrfull    in   FIFO full flags
//     busy           out  load in flight
//     done           out  all rows loaded
// ----------------------------------------------------------------------------
module mem_fifo_loader #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    WORD_WIDTH = 64,
  parameter int                    NUM_ROWS   = 9,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  read,
  input  logic [WORD_WIDTH-1:0] readdata,
  input  logic                  readdatavalid,
  input  logic                  waitrequest,
  output logic [DATA_WIDTH-1:0] fifo_data,
  output logic [NUM_ROWS-1:0]   fifo_wrreq,
  input  logic [NUM_ROWS-1:0]   fifo_wrfull,
  output logic                  busy,
  output logic                  done
);

  import minilab_pkg::*;

  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

  loader_state_t         state_q;
  logic [ROW_W-1:0]      row_q;
  logic                  read_q;
  logic [ADDR_WIDTH-1:0] address_q;
  logic                  busy_q;
  logic                  done_q;

  logic [ROW_W-1:0]      row_inc_d;
  logic [ADDR_WIDTH-1:0] addr_next_d;
  logic [NUM_ROWS-1:0]   row_sel;
  logic                  cur_full;
  logic                  in_unpack;
  logic                  load_word;
  logic                  push;
  logic                  last_byte;

  assign in_unpack = (state_q == UNPACK);

  // Decode the current row once; it drives both the write strobes and the
  // selection of the full flag that gates them.
  generate
    for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_row
      assign row_sel[gi]    = (row_q == ROW_W'(gi));
      assign fifo_wrreq[gi] = in_unpack && row_sel[gi] && !fifo_wrfull[gi];
    end
  endgenerate

  assign cur_full  = |(row_sel & fifo_wrfull);
  assign push      = in_unpack && !cur_full;
  // readdatavalid outside WAIT is a stray beat (e.g. after a reset abandoned
  // a read) and must not disturb the unpacker.
  assign load_word = (state_q == WAIT) && readdatavalid;

  assign row_inc_d   = row_q + 1'b1;
  assign addr_next_d = BASE_ADDR + ADDR_WIDTH'(row_inc_d);

  word_unpacker #(
    .DATA_WIDTH (DATA_WIDTH),
    .WORD_WIDTH (WORD_WIDTH)
  ) u_unpacker (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load_word),
    .word_i      (readdata),
    .shift_i     (push),
    .byte_o      (fifo_data),
    .last_byte_o (last_byte)
  );

  // Control FSM. read/address/busy/done are registered and updated on the
  // transition into the state that owns them, so they are valid from the
  // first cycle of that state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      row_q     <= '0;
      read_q    <= 1'b0;
      address_q <= BASE_ADDR;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q   <= REQ;
            row_q     <= '0;
            read_q    <= 1'b1;
            address_q <= BASE_ADDR;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
          end
        end
        REQ: begin
          // Request stays on the bus unchanged until the slave takes it.
          if (!waitrequest) begin
            state_q <= WAIT;
            read_q  <= 1'b0;
          end
        end
        WAIT: begin
          if (readdatavalid) begin
            state_q <= UNPACK;
          end
        end
        UNPACK: begin
          if (push && last_byte) begin
            if (row_q == LAST_ROW) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q   <= REQ;
              row_q     <= row_inc_d;
              read_q    <= 1'b1;
              address_q <= addr_next_d;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          read_q  <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign read    = read_q;
  assign address = address_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_mem_fifo_loader.sv
module tb_mem_fifo_loader;

  localparam int NR   = 9;
  localparam int BASE = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] address;
  logic        read;
  logic [63:0] readdata = '0;
  logic        readdatavalid = 1'b0;
  logic        waitrequest = 1'b0;
  logic [7:0]  fifo_data;
  logic [8:0]  fifo_wrreq;
  logic [8:0]  fifo_wrfull = '0;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  mem_fifo_loader #(
    .DATA_WIDTH (8),
    .WORD_WIDTH (64),
    .NUM_ROWS   (9),
    .ADDR_WIDTH (32),
    .BASE_ADDR  (32'd16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .address       (address),
    .read          (read),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .waitrequest   (waitrequest),
    .fifo_data     (fifo_data),
    .fifo_wrreq    (fifo_wrreq),
    .fifo_wrfull   (fifo_wrfull),
    .busy          (busy),
    .done          (done)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural model: load phase, rows finished, reads accepted, bytes pushed.
  int phase = 0;  // 0 idle, 1 loading, 2 done
  int rows_done = 0;
  int rows_acc = 0;
  int push_cnt [NR];
  int total_push = 0;
  int acc_addr [NR];
  logic [7:0] got [2][NR][8];
  int load_no = 0;
  logic        pend_v = 1'b0;
  logic [63:0] pend_d = '0;

  // Stimulus controls.
  logic start_drv = 1'b0;
  logic rst_drv = 1'b0;
  logic force_rdv = 1'b0;
  int wait_left = 0;
  int full_left = 0;
  int row2_read_cycles = 0;
  int row2_accepts = 0;
  int full_cycles = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mem_word(input int r);
    return 64'h0807060504030201 + (64'(r) << 56);
  endfunction

  // One clock cycle: drive inputs after the falling edge, let them settle,
  // then compare against the model and advance it to what the next rising
  // edge will do.
  task automatic tick();
    int r;
    logic acc;
    logic [63:0] exp_w;
    @(negedge clk);
    rst_n = rst_drv;
    start = start_drv;
    waitrequest = 1'b0;
    if (wait_left > 0 && read && address == 32'(BASE + 2)) begin
      waitrequest = 1'b1;
      wait_left--;
    end
    fifo_wrfull = '0;
    if (full_left > 0 && phase == 1 && rows_done == 4 && push_cnt[4] == 3) begin
      fifo_wrfull[4] = 1'b1;
      full_left--;
    end
    readdatavalid = pend_v || force_rdv;
    readdata = force_rdv ? 64'hdeadbeefcafef00d : pend_d;
    pend_v = 1'b0;
    #1;
    if (!rst_n) begin
      phase = 0;
      check("rst_read", read, 0);
      check("rst_addr", address, BASE);
      check("rst_wrreq", fifo_wrreq, 0);
      check("rst_data", fifo_data, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      return;
    end
    check("wrreq_onehot", $onehot0(fifo_wrreq), 1);
    check("busy", busy, phase == 1);
    check("done", done, phase == 2);
    if (phase != 1) check("quiet_when_not_loading", {read, |fifo_wrreq}, 0);
    if (read) begin
      check("read_addr", address, BASE + rows_done);
      check("no_push_during_read", fifo_wrreq, 0);
      if (rows_done == 2 && load_no == 0) row2_read_cycles++;
    end
    acc = read && !waitrequest;
    if (acc) begin
      check("one_outstanding", rows_acc, rows_done);
      if (rows_acc < NR) acc_addr[rows_acc] = int'(address);
      rows_acc++;
      pend_v = 1'b1;
      pend_d = mem_word(int'(address) - BASE);
      if (rows_done == 2 && load_no == 0) row2_accepts++;
    end
    if (fifo_wrfull[4]) begin
      full_cycles++;
      check("full_no_wrreq", fifo_wrreq, 0);
      check("full_data_held", fifo_data, 8'h04);
    end
    if (|fifo_wrreq) begin
      r = 0;
      for (int i = 0; i < NR; i++) if (fifo_wrreq[i]) r = i;
      check("push_row", r, rows_done);
      if (rows_done < NR && push_cnt[r] < 8) begin
        exp_w = mem_word(rows_done) >> (8 * push_cnt[rows_done]);
        check("push_data", fifo_data, exp_w[7:0]);
        if (load_no < 2) got[load_no][r][push_cnt[r]] = fifo_data;
      end
      push_cnt[r]++;
      total_push++;
      if (rows_done < NR && push_cnt[rows_done] == 8) begin
        rows_done++;
        if (rows_done == NR) phase = 2;
      end
    end
    if (start && phase != 1) begin
      phase = 1;
      rows_done = 0;
      rows_acc = 0;
      total_push = 0;
      for (int i = 0; i < NR; i++) push_cnt[i] = 0;
    end
  endtask

  task automatic run_to_done(input string name);
    int n;
    int hold;
    n = 0;
    hold = 0;
    while (phase != 2 && n < 2000) begin
      // Hold start for a few cycles mid-load; it must be ignored.
      if (rows_done == 5 && hold < 3) begin
        start_drv = 1'b1;
        hold++;
      end else begin
        start_drv = 1'b0;
      end
      tick();
      n++;
    end
    start_drv = 1'b0;
    checks++;
    if (phase != 2) begin
      failures++;
      $display("FAIL %s_timeout actual=%0d rows required=%0d rows", name, rows_done, NR);
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < NR; i++) begin
      push_cnt[i] = 0;
      acc_addr[i] = 0;
    end
    // Reset
    rst_drv = 1'b0;
    repeat (3) tick();
    rst_drv = 1'b1;
    tick();

    // Load 1: waitrequest stall on row 2, FIFO 4 full after its 3rd byte.
    wait_left = 3;
    full_left = 5;
    start_drv = 1'b1;
    tick();
    start_drv = 1'b0;
    run_to_done("load1");
    tick();
    check("load1_done", done, 1);
    check("load1_busy", busy, 0);
    check("load1_pushes", total_push, 72);
    check("row2_read_cycles", row2_read_cycles, 4);
    check("row2_accepts", row2_accepts, 1);
    check("full_cycles", full_cycles, 5);
    for (int i = 0; i < NR; i++) begin
      check("row_push_count", push_cnt[i], 8);
      check("accept_addr", acc_addr[i], 16 + i);
    end
    check("row0_byte0", got[0][0][0], 8'h01);
    check("row0_byte7", got[0][0][7], 8'h08);
    check("row4_byte3", got[0][4][3], 8'h04);
    check("row8_byte7", got[0][8][7], 8'h10);
    check("row3_byte6", got[0][3][6], 8'h07);

    // Load 2: start from DONE, contents must match load 1.
    load_no = 1;
    start_drv = 1'b1;
    tick();
    start_drv = 1'b0;
    run_to_done("load2");
    tick();
    check("load2_pushes", total_push, 72);
    check("load2_first_addr", acc_addr[0], 16);
    for (int r = 0; r < NR; r++)
      for (int b = 0; b < 8; b++)
        check("reload_same", got[1][r][b], got[0][r][b]);

    // Load 3: reset in the middle of row 6, then a stray readdatavalid.
    load_no = 2;
    start_drv = 1'b1;
    tick();
    start_drv = 1'b0;
    n = 0;
    while (!(rows_done == 6 && push_cnt[6] == 2) && n < 2000) begin
      tick();
      n++;
    end
    check("reached_row6", push_cnt[6], 2);
    rst_drv = 1'b0;
    repeat (2) tick();
    rst_drv = 1'b1;
    force_rdv = 1'b1;
    repeat (3) tick();
    force_rdv = 1'b0;
    repeat (3) tick();
    check("post_rst_data", fifo_data, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_done", done, 0);
    check("post_rst_read", read, 0);
    check("post_rst_addr", address, BASE);
    check("post_rst_wrreq", fifo_wrreq, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
